// File: rtl/key_debouncer_pkg.sv
// Shared types and helpers for the keyboard key debouncer and its tick prescaler.
// Holds the debounce FSM state encoding and the counter-width helper.
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_DEB   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_DEB = 2'd3
    } keyState_t;

    // Bits needed to hold 0..maxVal, never less than one bit.
    function automatic int cntWidth(input int maxVal);
        int w;
        w = $clog2(maxVal + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_debouncer_tick_prescaler.sv
// Free-running prescaler that pulses tick for one clk cycle every DIV cycles.
// Shared by the timed keyboard blocks; it is never realigned to input activity.
module tick_prescaler
    import key_debouncer_pkg::*;
#(
    parameter int DIV = 27000
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam int            CNT_W = cntWidth(DIV - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_tickCnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tickCnt <= '0;
        end else if (r_tickCnt >= LAST) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
        end
    end

    assign tick = (r_tickCnt == LAST);

endmodule

// File: rtl/key_debouncer.sv
// Debounces one active-low keyboard key and emits registered press, release and
// auto-repeat pulses; all timing is counted in prescaler ticks.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int TICK_DIV       = 27000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic clk,
    input  logic resetn,
    input  logic keySync,
    output logic keyLevel,
    output logic keyPress,
    output logic keyRelease,
    output logic keyRepeat
);

    localparam int DEB_W   = cntWidth(DEBOUNCE_TICKS - 1);
    localparam int REP_MAX = ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) - 1;
    localparam int REP_W   = cntWidth(REP_MAX);

    localparam logic [DEB_W-1:0] DEB_LIMIT      = DEB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [REP_W-1:0] REP_FIRST      = REP_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT       = REP_W'(REPEAT_RATE - 1);
    localparam bit               REPEAT_ENABLE  = (REPEAT_DELAY != 0);

    keyState_t        r_state;
    logic [DEB_W-1:0] r_debCnt;
    logic [REP_W-1:0] r_repCnt;
    logic             r_firstRep;

    keyState_t        w_stateNext;
    logic [DEB_W-1:0] w_debNext;
    logic [REP_W-1:0] w_repNext;
    logic [REP_W-1:0] w_repLimit;
    logic             w_firstNext;
    logic             w_levelNext;
    logic             w_pressNext;
    logic             w_releaseNext;
    logic             w_repeatNext;
    logic             w_tick;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .tick   (w_tick)
    );

    assign w_repLimit = r_firstRep ? REP_FIRST : REP_NEXT;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_RELEASED;
            r_debCnt   <= '0;
            r_repCnt   <= '0;
            r_firstRep <= 1'b0;
            keyLevel   <= 1'b0;
            keyPress   <= 1'b0;
            keyRelease <= 1'b0;
            keyRepeat  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_debCnt   <= w_debNext;
            r_repCnt   <= w_repNext;
            r_firstRep <= w_firstNext;
            keyLevel   <= w_levelNext;
            keyPress   <= w_pressNext;
            keyRelease <= w_releaseNext;
            keyRepeat  <= w_repeatNext;
        end
    end

    // Counters only advance on ticks and stop at their limit; a bounce back to
    // PRESSED leaves repCnt untouched so the repeat cadence carries on.
    always_comb begin
        w_stateNext   = r_state;
        w_debNext     = r_debCnt;
        w_repNext     = r_repCnt;
        w_firstNext   = r_firstRep;
        w_levelNext   = keyLevel;
        w_pressNext   = 1'b0;
        w_releaseNext = 1'b0;
        w_repeatNext  = 1'b0;

        case (r_state)
            ST_RELEASED: begin
                if (!keySync) begin
                    w_stateNext = ST_PRESS_DEB;
                    w_debNext   = '0;
                end
            end

            ST_PRESS_DEB: begin
                if (keySync) begin
                    w_stateNext = ST_RELEASED;
                    w_debNext   = '0;
                end else if (w_tick) begin
                    if (r_debCnt == DEB_LIMIT) begin
                        w_stateNext = ST_PRESSED;
                        w_levelNext = 1'b1;
                        w_pressNext = 1'b1;
                        w_repNext   = '0;
                        w_firstNext = 1'b1;
                    end else if (r_debCnt < DEB_LIMIT) begin
                        w_debNext = r_debCnt + 1'b1;
                    end
                end
            end

            ST_PRESSED: begin
                if (keySync) begin
                    w_stateNext = ST_RELEASE_DEB;
                    w_debNext   = '0;
                end else if (REPEAT_ENABLE && w_tick) begin
                    if (r_repCnt == w_repLimit) begin
                        w_repeatNext = 1'b1;
                        w_repNext    = '0;
                        w_firstNext  = 1'b0;
                    end else if (r_repCnt < w_repLimit) begin
                        w_repNext = r_repCnt + 1'b1;
                    end
                end
            end

            ST_RELEASE_DEB: begin
                if (!keySync) begin
                    w_stateNext = ST_PRESSED;
                end else if (w_tick) begin
                    if (r_debCnt == DEB_LIMIT) begin
                        w_stateNext   = ST_RELEASED;
                        w_levelNext   = 1'b0;
                        w_releaseNext = 1'b1;
                    end else if (r_debCnt < DEB_LIMIT) begin
                        w_debNext = r_debCnt + 1'b1;
                    end
                end
            end

            default: begin
                w_stateNext = ST_RELEASED;
                w_levelNext = 1'b0;
            end
        endcase
    end

endmodule
